mstr_wr_outstanding_ctrl: RTL and testbench

Master-side write-path controller in the crossbar clock domain. It sits directly downstream of MstrClockDomainCrossing, taking that block's int_master AW/W/B outputs, and feeds the crossbar master port.
- Limits outstanding write transactions to MAX_OUTSTANDING.
- Holds W beats until their AW has been accepted.
- Checks WLAST against AWLEN and flags unexpected B responses.

---
 rtl/mstr_wr_outstanding_ctrl_if.sv | 37 +++
 rtl/mstr_wr_outstanding_ctrl.sv | 121 ++++++++++++
 tb/tb_mstr_wr_outstanding_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mstr_wr_outstanding_ctrl_if.sv
// Write-path bundle (AW/W/B) between the clock-domain crossing and the crossbar master port.
// The master modport drives AW/W and BREADY; the slave modport is its mirror.
interface mstr_wr_outstanding_ctrl_if #(
  parameter int ID_WIDTH          = 4,
  parameter int AW_INFO_WIDTH     = 32,
  parameter int MASTER_DATA_WIDTH = 32,
  parameter int USER_WIDTH        = 1
);
  logic [ID_WIDTH-1:0]            AWID;
  logic [7:0]                     AWLEN;
  logic [AW_INFO_WIDTH-1:0]       AWINFO;
  logic                           AWVALID;
  logic                           AWREADY;
  logic [MASTER_DATA_WIDTH-1:0]   WDATA;
  logic [MASTER_DATA_WIDTH/8-1:0] WSTRB;
  logic                           WLAST;
  logic [USER_WIDTH-1:0]          WUSER;
  logic                           WVALID;
  logic                           WREADY;
  logic [ID_WIDTH-1:0]            BID;
  logic [1:0]                     BRESP;
  logic [USER_WIDTH-1:0]          BUSER;
  logic                           BVALID;
  logic                           BREADY;

  modport master (
    output AWID, AWLEN, AWINFO, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WUSER, WVALID, input WREADY,
    input BID, BRESP, BUSER, BVALID, output BREADY
  );

  modport slave (
    input AWID, AWLEN, AWINFO, AWVALID, output AWREADY,
    input WDATA, WSTRB, WLAST, WUSER, WVALID, output WREADY,
    output BID, BRESP, BUSER, BVALID, input BREADY
  );
endinterface

// File: rtl/mstr_wr_outstanding_ctrl.sv
// Master write-path controller: caps outstanding writes, holds W until its AW is accepted,
// and flags WLAST/AWLEN disagreement and stray B responses. Payloads pass with zero latency.
module mstr_wr_outstanding_ctrl #(
  parameter int MAX_OUTSTANDING = 4,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                  XBAR_CLK,
  input  logic                  sysReset,
  mstr_wr_outstanding_ctrl_if.slave  MASTER,
  mstr_wr_outstanding_ctrl_if.master int_master,
  output logic [CNT_W-1:0]      outstandingCnt,
  output logic                  wLastErr,
  output logic                  bUnexpErr
);
  localparam int IDX_W = $clog2(MAX_OUTSTANDING);
  localparam int PTR_W = IDX_W + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]       len_mem_q [MAX_OUTSTANDING];
  logic [7:0]       len_mem_d [MAX_OUTSTANDING];
  logic [7:0]       beat_q, beat_d;
  logic             wlast_err_q, wlast_err_d;
  logic             bunexp_err_q, bunexp_err_d;

  logic fifo_empty, fifo_full, aw_block, w_block, run;
  logic aw_hs, w_hs, b_hs, exp_last;

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                      (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
  assign aw_block   = (cnt_q == CNT_W'(MAX_OUTSTANDING)) | fifo_full;
  assign w_block    = fifo_empty;
  assign run        = ~sysReset;

  assign int_master.AWID    = MASTER.AWID;
  assign int_master.AWLEN   = MASTER.AWLEN;
  assign int_master.AWINFO  = MASTER.AWINFO;
  assign int_master.AWVALID = run & MASTER.AWVALID & ~aw_block;
  assign MASTER.AWREADY     = run & int_master.AWREADY & ~aw_block;

  assign int_master.WDATA   = MASTER.WDATA;
  assign int_master.WSTRB   = MASTER.WSTRB;
  assign int_master.WLAST   = MASTER.WLAST;
  assign int_master.WUSER   = MASTER.WUSER;
  assign int_master.WVALID  = run & MASTER.WVALID & ~w_block;
  assign MASTER.WREADY      = run & int_master.WREADY & ~w_block;

  assign MASTER.BID         = int_master.BID;
  assign MASTER.BRESP       = int_master.BRESP;
  assign MASTER.BUSER       = int_master.BUSER;
  assign MASTER.BVALID      = run & int_master.BVALID;
  assign int_master.BREADY  = run & MASTER.BREADY;

  assign aw_hs    = int_master.AWVALID & int_master.AWREADY;
  assign w_hs     = int_master.WVALID & int_master.WREADY;
  assign b_hs     = int_master.BVALID & int_master.BREADY;
  assign exp_last = (beat_q == len_mem_q[rd_ptr_q[IDX_W-1:0]]);

  always_comb begin
    cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    len_mem_d    = len_mem_q;
    beat_d       = beat_q;
    wlast_err_d  = wlast_err_q;
    bunexp_err_d = bunexp_err_q;

    if (aw_hs) begin
      len_mem_d[wr_ptr_q[IDX_W-1:0]] = MASTER.AWLEN;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    // Burst boundaries follow AWLEN; WLAST is only cross-checked.
    if (w_hs) begin
      if (exp_last) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        beat_d   = 8'd0;
      end else begin
        beat_d   = beat_q + 8'd1;
      end
      if (MASTER.WLAST != exp_last) wlast_err_d = 1'b1;
    end

    if (b_hs && (cnt_q == '0)) bunexp_err_d = 1'b1;

    case ({aw_hs, b_hs})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge XBAR_CLK) begin
    if (sysReset) begin
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      beat_q       <= '0;
      wlast_err_q  <= 1'b0;
      bunexp_err_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      beat_q       <= beat_d;
      wlast_err_q  <= wlast_err_d;
      bunexp_err_q <= bunexp_err_d;
    end
  end

  // Length storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge XBAR_CLK) begin
    len_mem_q <= len_mem_d;
  end

  assign outstandingCnt = cnt_q;
  assign wLastErr       = wlast_err_q;
  assign bUnexpErr      = bunexp_err_q;
endmodule

// File: tb/tb_mstr_wr_outstanding_ctrl.sv
// Bench for mstr_wr_outstanding_ctrl: directed scenarios plus random traffic, all checked
// against a transaction-level model (length queue, outstanding count, beat index).
module tb_mstr_wr_outstanding_ctrl;
  localparam int MAXO  = 4;
  localparam int CNT_W = $clog2(MAXO) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        awvalid, wvalid, wlast, bready;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [31:0] awinfo, wdata;
  logic [3:0]  wstrb;
  logic        wuser;
  logic        awready_x, wready_x, bvalid_x, buser_x;
  logic [3:0]  bid_x;
  logic [1:0]  bresp_x;

  logic [CNT_W-1:0] outstandingCnt;
  logic             wLastErr, bUnexpErr;

  mstr_wr_outstanding_ctrl_if #(.ID_WIDTH(4), .AW_INFO_WIDTH(32), .MASTER_DATA_WIDTH(32), .USER_WIDTH(1)) up_if();
  mstr_wr_outstanding_ctrl_if #(.ID_WIDTH(4), .AW_INFO_WIDTH(32), .MASTER_DATA_WIDTH(32), .USER_WIDTH(1)) dn_if();

  assign up_if.AWID    = awid;
  assign up_if.AWLEN   = awlen;
  assign up_if.AWINFO  = awinfo;
  assign up_if.AWVALID = awvalid;
  assign up_if.WDATA   = wdata;
  assign up_if.WSTRB   = wstrb;
  assign up_if.WLAST   = wlast;
  assign up_if.WUSER   = wuser;
  assign up_if.WVALID  = wvalid;
  assign up_if.BREADY  = bready;
  assign dn_if.AWREADY = awready_x;
  assign dn_if.WREADY  = wready_x;
  assign dn_if.BID     = bid_x;
  assign dn_if.BRESP   = bresp_x;
  assign dn_if.BUSER   = buser_x;
  assign dn_if.BVALID  = bvalid_x;

  mstr_wr_outstanding_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
    .XBAR_CLK      (clk),
    .sysReset      (rst),
    .MASTER        (up_if),
    .int_master    (dn_if),
    .outstandingCnt(outstandingCnt),
    .wLastErr      (wLastErr),
    .bUnexpErr     (bUnexpErr)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level reference state
  int m_q[$];
  int m_cnt  = 0;
  int m_beat = 0;
  bit m_werr = 0;
  bit m_berr = 0;

  function automatic bit model_last();
    return (m_q.size() > 0) && (m_beat == m_q[0]);
  endfunction

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic step();
    bit aw_blk, w_blk, e_awv, e_awr, e_wv, e_wr, e_bv, e_br, aw, w, b, last;
    #1;
    aw_blk = (m_cnt == MAXO) || (m_q.size() == MAXO);
    w_blk  = (m_q.size() == 0);
    e_awv  = !rst && awvalid && !aw_blk;
    e_awr  = !rst && awready_x && !aw_blk;
    e_wv   = !rst && wvalid && !w_blk;
    e_wr   = !rst && wready_x && !w_blk;
    e_bv   = !rst && bvalid_x;
    e_br   = !rst && bready;
    chk("int_awvalid", dn_if.AWVALID, e_awv);
    chk("awready",     up_if.AWREADY, e_awr);
    chk("int_wvalid",  dn_if.WVALID,  e_wv);
    chk("wready",      up_if.WREADY,  e_wr);
    chk("bvalid",      up_if.BVALID,  e_bv);
    chk("int_bready",  dn_if.BREADY,  e_br);
    chk("cnt",         outstandingCnt, m_cnt);
    chk("wlast_err",   wLastErr,      m_werr);
    chk("bunexp_err",  bUnexpErr,     m_berr);
    chk("awpay", {dn_if.AWID, dn_if.AWLEN, dn_if.AWINFO}, {awid, awlen, awinfo});
    chk("wpay",  {dn_if.WDATA, dn_if.WSTRB, dn_if.WLAST, dn_if.WUSER}, {wdata, wstrb, wlast, wuser});
    chk("bpay",  {up_if.BID, up_if.BRESP, up_if.BUSER}, {bid_x, bresp_x, buser_x});

    if (rst) begin
      m_q.delete();
      m_cnt = 0; m_beat = 0; m_werr = 0; m_berr = 0;
    end else begin
      aw = e_awv && awready_x;
      w  = e_wv && wready_x;
      b  = e_bv && bready;
      if (w) begin
        last = model_last();
        if (wlast != last) m_werr = 1;
        if (last) begin
          void'(m_q.pop_front());
          m_beat = 0;
        end else begin
          m_beat++;
        end
      end
      if (aw) m_q.push_back(int'(awlen));
      if (b && m_cnt == 0) m_berr = 1;
      if (aw && !b) m_cnt++;
      else if (b && !aw && m_cnt > 0) m_cnt--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    awvalid = 0; wvalid = 0; wlast = 0; bready = 1;
    awid = 4'h3; awlen = 8'd0; awinfo = 32'hA5A5_0001;
    wdata = 32'h1234_5678; wstrb = 4'hF; wuser = 1'b0;
    awready_x = 1; wready_x = 1; bvalid_x = 0;
    bid_x = 4'h5; bresp_x = 2'b00; buser_x = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    step();
    rst = 0;
    chk("rst_cnt", outstandingCnt, 0);
    chk("rst_flags", {wLastErr, bUnexpErr}, 2'b00);
  endtask

  initial begin
    idle();
    @(negedge clk);
    do_reset();

    // Outstanding limit; the length FIFO is drained so only the count blocks the 5th AW
    awvalid = 1; awlen = 8'd0;
    repeat (4) step();
    chk("lim_cnt4", outstandingCnt, 4);
    awvalid = 0; wvalid = 1; wlast = 1;
    repeat (4) step();
    wvalid = 0; awvalid = 1;
    #1;
    chk("lim_awv_blocked", dn_if.AWVALID, 0);
    chk("lim_awr_blocked", up_if.AWREADY, 0);
    bvalid_x = 1;
    step();
    bvalid_x = 0;
    #1;
    chk("lim_awv_after_b", dn_if.AWVALID, 1);
    chk("lim_awr_after_b", up_if.AWREADY, 1);
    step();
    awvalid = 0;
    chk("lim_cnt_refill", outstandingCnt, 4);

    // W before AW
    do_reset();
    wvalid = 1; wlast = 0;
    step();
    step();
    awvalid = 1; awlen = 8'd3;
    #1 chk("wfirst_blk_aw_cycle", dn_if.WVALID, 0);
    step();
    awvalid = 0;
    for (int i = 0; i < 4; i++) begin
      wlast = (i == 3);
      #1 chk("wfirst_pass", dn_if.WVALID, 1);
      step();
    end
    wlast = 0;
    #1 chk("wfirst_empty", dn_if.WVALID, 0);
    chk("wfirst_noerr", wLastErr, 0);
    wvalid = 0;

    // Early WLAST
    do_reset();
    awvalid = 1; awlen = 8'd1;
    step();
    awvalid = 0; wvalid = 1; wlast = 1;
    step();
    chk("early_last_err", wLastErr, 1);
    step();
    wlast = 0;
    #1 chk("early_last_popped", dn_if.WVALID, 0);
    chk("early_last_sticky", wLastErr, 1);
    wvalid = 0;

    // Unexpected B
    do_reset();
    bvalid_x = 1;
    step();
    bvalid_x = 0;
    chk("bunexp_flag", bUnexpErr, 1);
    chk("bunexp_cnt0", outstandingCnt, 0);

    // Simultaneous AW and B at count 2
    do_reset();
    awvalid = 1; awlen = 8'd0;
    step();
    step();
    chk("simul_pre", outstandingCnt, 2);
    bvalid_x = 1;
    step();
    chk("simul_cnt", outstandingCnt, 2);
    chk("simul_noerr", bUnexpErr, 0);

    // Back-to-back single-beat bursts
    do_reset();
    awvalid = 1; awlen = 8'd0; wvalid = 1; wlast = 1;
    step();
    bvalid_x = 1;
    for (int i = 0; i < 8; i++) begin
      #1 chk("b2b_wvalid", dn_if.WVALID, 1);
      step();
    end
    chk("b2b_noerr", {wLastErr, bUnexpErr}, 2'b00);
    chk("b2b_cnt", outstandingCnt, 1);

    // Reset mid-burst
    do_reset();
    bvalid_x = 1;
    step();
    bvalid_x = 0;
    awvalid = 1; awlen = 8'd3;
    step();
    awvalid = 0; wvalid = 1; wlast = 0;
    step();
    step();
    rst = 1; awvalid = 1; bvalid_x = 1;
    #1 chk("rst_mid_outs", {dn_if.AWVALID, up_if.AWREADY, dn_if.WVALID, up_if.WREADY,
                             up_if.BVALID, dn_if.BREADY}, 6'b0);
    step();
    chk("rst_mid_cnt", outstandingCnt, 0);
    chk("rst_mid_flags", {wLastErr, bUnexpErr}, 2'b00);
    idle();
    rst = 0;
    awvalid = 1; awlen = 8'd2;
    step();
    awvalid = 0; wvalid = 1;
    for (int i = 0; i < 3; i++) begin
      wlast = (i == 2);
      step();
    end
    wvalid = 0; wlast = 0; bvalid_x = 1;
    step();
    bvalid_x = 0;
    chk("post_rst_clean", {wLastErr, bUnexpErr}, 2'b00);
    chk("post_rst_cnt", outstandingCnt, 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      awvalid   = ($urandom_range(0, 99) < 50);
      awid      = 4'($urandom);
      awlen     = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 15)) : 8'($urandom_range(0, 3));
      awinfo    = $urandom;
      awready_x = ($urandom_range(0, 99) < 70);
      wvalid    = ($urandom_range(0, 99) < 70);
      wready_x  = ($urandom_range(0, 99) < 70);
      wdata     = $urandom;
      wstrb     = 4'($urandom);
      wuser     = 1'($urandom);
      wlast     = model_last() ^ ($urandom_range(0, 19) == 0);
      bvalid_x  = ($urandom_range(0, 99) < 30);
      bready    = ($urandom_range(0, 99) < 70);
      bid_x     = 4'($urandom);
      bresp_x   = 2'($urandom);
      buser_x   = 1'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
